fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage feeding the decoder. Reads 64-byte cache lines over the Sysbus
//  starting at the program entry point, splits each 64-bit beat into two 32-bit instructions,
//  and queues them with their PCs. Presents one instruction per cycle to the decoder over a
//  valid/ready handshake. Supports a redirect (branch/jump) that flushes the queue.
// PARAMETERS
//  BUS_DATA_WIDTH  64  Sysbus data width; two instructions per beat
//  BUS_TAG_WIDTH   13  Sysbus tag width
//  LINE_BEATS       8  beats per line (64 B line)
//  FIFO_DEPTH      32  instruction queue entries; must be >= 2*LINE_BEATS, power of 2
// PORTS
//  clk            in   1    single clock
//  reset          in   1    asynchronous, active-high
//  entry          in   64   program entry PC, sampled while reset is high
//  bus_reqcyc     out  1    Sysbus request valid
//  bus_reqack     in   1    Sysbus request accepted
//  bus_req        out  64   request address (line aligned)
//  bus_reqtag     out  13   {`SYSBUS_READ,`SYSBUS_MEMORY,8'h00}
//  bus_respcyc    in   1    response beat valid
//  bus_respack    out  1    response beat accepted
//  bus_resp       in   64   response beat data
//  bus_resptag    in   13   response tag (ignored)
//  redirect_valid in   1    1-cycle pulse: refetch from redirect_pc
//  redirect_pc    in   64   new fetch PC, 4-byte aligned
//  inst_valid     out  1    queue not empty
//  inst_ready     in   1    decoder accepts head entry
//  inst_out       out  64   {32'h0, instruction}
//  inst_pc        out  64   PC of inst_out
//  fetch_done     out  1    fetch halted (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=REQ, fetch_pc=entry, queue empty; all outputs 0 except bus_reqtag (constant).
//  States: REQ -> WAIT (on reqcyc&reqack) -> (last beat) DRAIN or REQ; HALT terminal.
//   REQ: bus_reqcyc=1, bus_req=fetch_pc&~63, held stable until bus_reqack.
//     Requests only when free entries >= 2*LINE_BEATS; otherwise sit in DRAIN, reqcyc=0.
//   WAIT: bus_respack=bus_respcyc; each beat k (0..7, ascending from line base)
//     carries PC base+8k in [31:0] and base+8k+4 in [63:32]. Low half enqueued first.
//     Instructions with PC < fetch_pc are dropped (mid-line entry/redirect).
//     After beat 7: fetch_pc = base+64, go REQ (room) or DRAIN (no room).
//  Queue: head transfer on inst_valid&inst_ready; up to 2 pushes + 1 pop per cycle.
//   Full: cannot occur (room check before REQ); assertion fires on overflow.
//   Empty: inst_valid=0, inst_out/inst_pc hold last value.
//  Redirect: queue flushed same edge; fetch_pc=redirect_pc. In REQ with request not yet
//   acked: bus_req updates next cycle. In WAIT: remaining beats still acked but discarded,
//   then REQ. Redirect wins over simultaneous push/pop. Redirect in HALT: leave HALT, go REQ.
//  Latency: first inst_valid 1 cycle after the beat containing it is acked.
//  PC arithmetic 64-bit, wraps modulo 2^64. Beat count wraps 7->0 per line.
//  Reset mid-transaction: in-flight request/beats abandoned, reqcyc/respack drop immediately.
// CONFIGURATION
//  FETCH_HALT_ON_ZERO_EN defined: an enqueued-eligible instruction 32'h0 is not enqueued;
//   remaining beats of the line are acked and discarded, state -> HALT, no further
//   requests; fetch_done=1 once the queue drains empty. Left only by reset or redirect.
//  Not defined: 32'h0 is enqueued as a normal instruction; HALT unreachable; fetch_done=0.
// TESTING
//  1. entry=0x1000, beats {i1,i0}..: bus_req=0x1000, 16 instrs out, inst_pc 0x1000..0x103C.
//  2. entry=0x1014: first inst_pc=0x1014 (high half of beat 2); 11 instrs from line 0.
//  3. inst_ready=0 for 200 cycles: after 2 lines (32 entries) reqcyc stays 0; resumes
//     REQ at 0x1040+ once 16 entries popped; no loss/duplication.
//  4. redirect_pc=0x2008 during beat 3 of line 0x1000: beats 4..7 acked, dropped; next
//     bus_req=0x2000; first inst_pc=0x2008; no 0x10xx PCs after redirect.
//  5. EN defined, word 32'h0 at 0x1020: instrs 0x1000..0x101C out, fetch_done=1 after
//     drain; EN undefined: 0x1020 delivered as 64'h0, fetch continues.
//  6. reset asserted in WAIT mid-line: reqcyc/respack/inst_valid 0 same cycle; restart at entry.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: fetches 64-byte lines over the Sysbus into a 2-push/1-pop instruction queue.
// Optional FETCH_HALT_ON_ZERO_EN: stop fetching at the first eligible 32'h0 instruction.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module fetch_unit #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8,
    parameter int FIFO_DEPTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    output logic                      bus_reqcyc,
    input  logic                      bus_reqack,
    output logic [63:0]               bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [63:0]               inst_out,
    output logic [63:0]               inst_pc,
    output logic                      fetch_done
);

    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int BEAT_W     = $clog2(LINE_BEATS);
    localparam int BEAT_BYTES = BUS_DATA_WIDTH / 8;
    localparam int BEAT_SH    = $clog2(BEAT_BYTES);
    localparam int LINE_BYTES = LINE_BEATS * BEAT_BYTES;
    localparam logic [63:0]    LINE_MASK = ~64'(LINE_BYTES - 1);
    localparam logic [PTR_W:0] ROOM_MAX  = (PTR_W + 1)'(FIFO_DEPTH - 2 * LINE_BEATS);

    typedef enum logic [1:0] {REQ, WAIT, DRAIN, HALT} state_t;

    state_t            state, state_n;
    logic [63:0]       fetch_pc, fetch_pc_n;
    logic [63:0]       line_base;
    logic [BEAT_W-1:0] beat_cnt;
    logic              drop_line, drop_n;
    logic              halt_pend, halt_pend_n;

    logic [95:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr, rptr, wptr_1;
    logic [PTR_W:0]    count, count_n;
    logic [31:0]       last_inst;
    logic [63:0]       last_pc;
    logic [95:0]       head;

    logic              beat_fire, beat_take, last_beat, pop, room;
    logic [63:0]       lo_pc, hi_pc;
    logic [31:0]       lo_inst, hi_inst;
    logic              lo_ok, hi_ok, halt_lo, halt_hi, halt_now, push_lo, push_hi;
    logic              unused_tag;

    assign unused_tag  = ^bus_resptag;
    assign bus_reqtag  = BUS_TAG_WIDTH'({`SYSBUS_READ, `SYSBUS_MEMORY, 8'h00});
    assign bus_reqcyc  = (state == REQ) && !reset;
    assign bus_req     = reset ? 64'h0 : (fetch_pc & LINE_MASK);
    assign bus_respack = (state == WAIT) && bus_respcyc && !reset;

    assign beat_fire = bus_respack;
    assign beat_take = beat_fire && !drop_line && !redirect_valid;
    assign last_beat = (beat_cnt == BEAT_W'(LINE_BEATS - 1));
    assign lo_pc     = line_base + (64'(beat_cnt) << BEAT_SH);
    assign hi_pc     = lo_pc + 64'd4;
    assign lo_inst   = bus_resp[31:0];
    assign hi_inst   = bus_resp[63:32];
    // Words before fetch_pc belong to a mid-line entry or redirect target and are skipped.
    assign lo_ok     = beat_take && (lo_pc >= fetch_pc);
    assign hi_ok     = beat_take && (hi_pc >= fetch_pc);

`ifdef FETCH_HALT_ON_ZERO_EN
    assign halt_lo    = lo_ok && (lo_inst == 32'h0);
    assign halt_hi    = hi_ok && (hi_inst == 32'h0) && !halt_lo;
    assign fetch_done = (state == HALT) && (count == '0);
`else
    assign halt_lo    = 1'b0;
    assign halt_hi    = 1'b0;
    assign fetch_done = 1'b0;
`endif

    assign halt_now = halt_lo || halt_hi;
    assign push_lo  = lo_ok && !halt_lo;
    assign push_hi  = hi_ok && !halt_hi && !halt_lo;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign room       = (count <= ROOM_MAX);
    assign wptr_1     = wptr + PTR_W'(1);
    assign head       = mem[rptr];
    assign inst_out   = {32'h0, inst_valid ? head[31:0] : last_inst};
    assign inst_pc    = inst_valid ? head[95:32] : last_pc;

    always_comb begin
        count_n = count + (PTR_W + 1)'(push_lo) + (PTR_W + 1)'(push_hi) - (PTR_W + 1)'(pop);
        if (redirect_valid)
            count_n = '0;
    end

    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        drop_n      = drop_line;
        halt_pend_n = halt_pend;
        case (state)
            REQ: begin
                if (bus_reqack) begin
                    state_n     = WAIT;
                    drop_n      = redirect_valid;
                    halt_pend_n = 1'b0;
                end
            end
            WAIT: begin
                if (beat_fire) begin
                    if (halt_now) begin
                        drop_n      = 1'b1;
                        halt_pend_n = 1'b1;
                    end
                    if (last_beat) begin
                        drop_n      = 1'b0;
                        halt_pend_n = 1'b0;
                        if (halt_pend || halt_now) begin
                            state_n = HALT;
                        end else begin
                            state_n = (count_n <= ROOM_MAX) ? REQ : DRAIN;
                            if (!drop_line)
                                fetch_pc_n = line_base + 64'(LINE_BYTES);
                        end
                    end
                end
            end
            DRAIN: begin
                if (room)
                    state_n = REQ;
            end
            default: ;
        endcase
        // A redirect acked together with the old request still has to swallow that line.
        if (redirect_valid) begin
            fetch_pc_n  = redirect_pc;
            halt_pend_n = 1'b0;
            if (state == WAIT) begin
                if (beat_fire && last_beat) begin
                    state_n = REQ;
                    drop_n  = 1'b0;
                end else begin
                    drop_n  = 1'b1;
                end
            end else if (!(state == REQ && bus_reqack)) begin
                state_n = REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= REQ;
            fetch_pc  <= entry;
            drop_line <= 1'b0;
            halt_pend <= 1'b0;
            beat_cnt  <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            last_inst <= 32'h0;
            last_pc   <= 64'h0;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            drop_line <= drop_n;
            halt_pend <= halt_pend_n;
            count     <= count_n;
            if (beat_fire)
                beat_cnt <= beat_cnt + BEAT_W'(1);
            wptr <= wptr + PTR_W'(push_lo) + PTR_W'(push_hi);
            if (redirect_valid)
                rptr <= wptr;
            else if (pop)
                rptr <= rptr + PTR_W'(1);
            if (inst_valid) begin
                last_inst <= head[31:0];
                last_pc   <= head[95:32];
            end
            assert (redirect_valid || count_n <= (PTR_W + 1)'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (state == REQ && bus_reqack)
            line_base <= fetch_pc & LINE_MASK;
        if (push_lo)
            mem[wptr] <= {lo_pc, lo_inst};
        if (push_hi)
            mem[push_lo ? wptr_1 : wptr] <= {hi_pc, hi_inst};
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized Sysbus memory and decoder against an in-order PC-stream model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic        bus_reqcyc, bus_reqack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc, bus_respack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [63:0] inst_out, inst_pc;
    logic        fetch_done;

    fetch_unit dut (
        .clk(clk), .reset(reset), .entry(entry),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req),
        .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
        .inst_pc(inst_pc), .fetch_done(fetch_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: the decoder must see a contiguous PC stream from entry, restarted at each redirect.
    logic [63:0] exp_pc, req_exp, last_pc, last_out, resp_line;
    int          delivered, acks, beat_k, ready_pct, redir_pct;
    logic        seen, resp_active, zero_at_1020, arm_r4, lat_arm, lat_pending;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mw(input logic [63:0] a);
        if (zero_at_1020 && a == 64'h1020) return 32'h0;
        return {~a[15:0], a[31:16] ^ 16'h1234};
    endfunction

    task automatic init_model(input logic [63:0] e);
        exp_pc      = e;
        req_exp     = e & ~64'h3F;
        delivered   = 0;
        acks        = 0;
        seen        = 1'b0;
        resp_active = 1'b0;
        beat_k      = 0;
        lat_pending = 1'b0;
    endtask

    task automatic do_reset(input logic [63:0] e, input logic chk);
        reset = 1'b1; entry = e;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = 64'h0; bus_resptag = 13'h0;
        redirect_valid = 1'b0; redirect_pc = 64'h0; inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (chk) begin
            check("rst_reqcyc", bus_reqcyc, 0);
            check("rst_respack", bus_respack, 0);
            check("rst_valid", inst_valid, 0);
            check("rst_out", inst_out, 0);
            check("rst_pc", inst_pc, 0);
            check("rst_req", bus_req, 0);
            check("rst_done", fetch_done, 0);
            check("rst_tag", bus_reqtag, 13'h1100);
        end
        reset = 1'b0;
        init_model(e);
        #1;
        if (chk) begin
            check("post_rst_reqcyc", bus_reqcyc, 1);
            check("post_rst_req", bus_req, e & ~64'h3F);
        end
    endtask

    // One clock: drive at posedge+1, sample settled outputs, advance model, wait next edge.
    task automatic step();
        logic [63:0] addr;
        logic        fired;
        redirect_valid = 1'b0;
        bus_reqack = bus_reqcyc && ($urandom_range(0, 99) < 60);
        if (resp_active) begin
            addr = resp_line + 64'(beat_k * 8);
            bus_respcyc = ($urandom_range(0, 99) < 75);
            bus_resp = {mw(addr + 64'd4), mw(addr)};
        end else begin
            bus_respcyc = 1'b0;
            bus_resp = {$urandom, $urandom};
        end
        bus_resptag = 13'($urandom);
        inst_ready = ($urandom_range(0, 99) < ready_pct);
        if (arm_r4 && resp_active && beat_k == 3) begin
            bus_respcyc = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc = 64'h2008;
            arm_r4 = 1'b0;
        end else if (redir_pct > 0 && $urandom_range(0, 99) < redir_pct) begin
            redirect_valid = 1'b1;
            redirect_pc = {48'h0, 16'($urandom) & 16'hFFFC};
        end
        if (redirect_valid) inst_ready = 1'b0;
        #1;
        if (lat_pending) begin
            check("latency", inst_valid, 1);
            lat_pending = 1'b0;
        end
        if (inst_valid) begin
            last_pc = inst_pc; last_out = inst_out; seen = 1'b1;
        end else if (seen) begin
            check("hold_pc", inst_pc, last_pc);
            check("hold_out", inst_out, last_out);
        end
        if (resp_active) check("respack", bus_respack, bus_respcyc);
        fired = bus_respcyc && bus_respack;
        if (fired) begin
            if (lat_arm) begin
                check("latency_pre", inst_valid, 0);
                lat_arm = 1'b0;
                lat_pending = 1'b1;
            end
            beat_k++;
            if (beat_k == 8) resp_active = 1'b0;
        end
        if (bus_reqcyc && bus_reqack) begin
            check("req_busy", resp_active, 0);
            check("req_addr", bus_req, req_exp);
            req_exp += 64'd64;
            acks++;
            resp_active = 1'b1; resp_line = bus_req; beat_k = 0;
        end
        if (inst_valid && inst_ready) begin
`ifdef FETCH_HALT_ON_ZERO_EN
            check("zero_not_enq", mw(exp_pc) != 32'h0, 1);
`endif
            check("inst_pc", inst_pc, exp_pc);
            check("inst_out", inst_out, {32'h0, mw(exp_pc)});
            exp_pc += 64'd4;
            delivered++;
        end
        if (redirect_valid) begin
            exp_pc = redirect_pc;
            req_exp = redirect_pc & ~64'h3F;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int target, input int max_cycles);
        for (int c = 0; c < max_cycles && delivered < target; c++) step();
    endtask

    initial begin
        reset = 1'b1; zero_at_1020 = 1'b0; arm_r4 = 1'b0; lat_arm = 1'b0;
        ready_pct = 100; redir_pct = 0;

        // Straight-line fetch from an aligned entry, including first-beat latency
        do_reset(64'h1000, 1'b1);
        lat_arm = 1'b1;
        run(40, 2000);
        check("s1_count", delivered, 40);

        // Mid-line entry: first word is the high half of beat 2
        do_reset(64'h1014, 1'b0);
        ready_pct = 80;
        run(11, 2000);
        check("s2_count", delivered, 11);

        // Decoder stall: exactly two lines fit, then fetch resumes after 16 pops
        do_reset(64'h1000, 1'b0);
        ready_pct = 0;
        for (int c = 0; c < 200; c++) step();
        check("s3_acks", acks, 2);
        check("s3_reqcyc", bus_reqcyc, 0);
        check("s3_valid", inst_valid, 1);
        ready_pct = 100;
        run(48, 2000);
        check("s3_count", delivered, 48);
        check("s3_resume", acks >= 3, 1);

        // Redirect during beat 3 of the first line
        do_reset(64'h1000, 1'b0);
        ready_pct = 50; arm_r4 = 1'b1;
        run(24, 3000);
        check("s4_count", delivered, 24);
        check("s4_redirected", arm_r4, 0);

        // Zero instruction at 0x1020
        do_reset(64'h1000, 1'b0);
        zero_at_1020 = 1'b1; ready_pct = 70;
`ifdef FETCH_HALT_ON_ZERO_EN
        run(8, 2000);
        check("s5_count", delivered, 8);
        ready_pct = 100;
        for (int c = 0; c < 100 && !fetch_done; c++) step();
        check("s5_done", fetch_done, 1);
        check("s5_empty", inst_valid, 0);
        check("s5_noreq", bus_reqcyc, 0);
`else
        run(24, 3000);
        check("s5_count", delivered, 24);
        check("s5_done", fetch_done, 0);
`endif
        zero_at_1020 = 1'b0;

        // Asynchronous reset in the middle of a line, then restart at a new entry
        do_reset(64'h1000, 1'b0);
        ready_pct = 0;
        for (int c = 0; c < 200 && !(resp_active && beat_k == 4); c++) step();
        bus_respcyc = 1'b1; bus_reqack = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        #1;
        check("s6_pre_respack", bus_respack, 1);
        reset = 1'b1;
        #1;
        check("s6_reqcyc", bus_reqcyc, 0);
        check("s6_respack", bus_respack, 0);
        check("s6_valid", inst_valid, 0);
        entry = 64'h3000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        init_model(64'h3000);
        ready_pct = 90;
        run(10, 2000);
        check("s6_count", delivered, 10);

        // PC wrap modulo 2^64
        do_reset(64'hFFFF_FFFF_FFFF_FFD8, 1'b0);
        ready_pct = 80;
        run(20, 2000);
        check("wrap_count", delivered, 20);

        // Random entries, decoder back-pressure and redirects
        for (int r = 0; r < 4; r++) begin
            do_reset({48'h0, 16'($urandom) & 16'hFFFC}, 1'b0);
            ready_pct = 60; redir_pct = 2;
            for (int c = 0; c < 400; c++) step();
            check("rand_progress", delivered > 0, 1);
        end
        redir_pct = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
